// File: rtl/updn_bcd_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : updn_pkg
//  Purpose  : Segment table and BCD helper functions for updn_bcd_counter.
//  Revision : 1.0  initial release
// ============================================================================
package updn_pkg;

  localparam int MAX_DIGITS = 4;

  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  function automatic logic [15:0] to_bcd(input int value, input int digits);
    logic [15:0] r;
    int          v;
    r = '0;
    v = value;
    for (int d = 0; d < MAX_DIGITS; d++) begin
      if (d < digits) begin
        r[4*d +: 4] = 4'(v % 10);
        v           = v / 10;
      end
    end
    return r;
  endfunction

  // Result is {carry, value}; carry set when every active digit rolled 9->0.
  function automatic logic [16:0] bcd_inc(input logic [15:0] v, input int digits);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < MAX_DIGITS; d++) begin
      if (d < digits && c) begin
        if (v[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  function automatic logic [16:0] bcd_dec(input logic [15:0] v, input int digits);
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int d = 0; d < MAX_DIGITS; d++) begin
      if (d < digits && b) begin
        if (v[4*d +: 4] == 4'd0) begin
          r[4*d +: 4] = 4'd9;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] - 4'd1;
          b           = 1'b0;
        end
      end
    end
    return {b, r};
  endfunction

endpackage
`default_nettype wire

// File: rtl/updn_bcd_counter_if.sv
`default_nettype none
// ============================================================================
//  Module   : updn_bcd_counter_if
//  Purpose  : Button, load and display bundle of updn_bcd_counter.
//  Revision : 1.0  initial release
// ============================================================================
interface updn_bcd_counter_if #(
  parameter int DIGITS = 2
);
  logic [1:0]          i_Push;
  logic                i_Load;
  logic [4*DIGITS-1:0] i_LoadVal;
  logic [4*DIGITS-1:0] o_Cnt;
  logic [3:0]          o_LED;
  logic                o_Wrap;
  logic [6:0]          o_FND;
  logic [DIGITS-1:0]   o_DigSel;

  modport master (
    output i_Push, i_Load, i_LoadVal,
    input  o_Cnt, o_LED, o_Wrap, o_FND, o_DigSel
  );

  modport slave (
    input  i_Push, i_Load, i_LoadVal,
    output o_Cnt, o_LED, o_Wrap, o_FND, o_DigSel
  );
endinterface
`default_nettype wire

// File: rtl/updn_bcd_counter_push_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : push_debounce
//  Purpose  : Synchronise and debounce one active-low button; emit press pulse.
//  Revision : 1.0  initial release
// ============================================================================
module push_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Raw,
  output logic o_Fall
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic          r_fall;
  logic [CW-1:0] r_cnt;
  logic          w_accept;

  // Accept on the DB_CYCLES-th consecutive cycle of disagreement.
  assign w_accept = (r_s2 != r_level) && (r_cnt == CW'(DB_CYCLES - 1));

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1   <= i_Raw;
      r_s2   <= r_s1;
      r_fall <= 1'b0;
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt   <= '0;
        r_level <= r_s2;
        r_fall  <= r_level;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_Fall = r_fall;
endmodule
`default_nettype wire

// File: rtl/updn_bcd_counter.sv
`default_nettype none
// ============================================================================
//  Module   : updn_bcd_counter
//  Purpose  : Debounced up/down BCD counter with load, wrap/saturate and a
//             multiplexed 7-segment display. UPDN_LZB_EN enables leading-zero
//             blanking.
//  Revision : 1.0  initial release
// ============================================================================
module updn_bcd_counter
  import updn_pkg::*;
#(
  parameter int DIGITS    = 2,
  parameter int CNT_MAX   = 99,
  parameter int DB_CYCLES = 4,
  parameter int SCAN_DIV  = 16,
  parameter int SAT_MODE  = 0
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  updn_bcd_counter_if.slave   bus
);
  localparam int CW = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] c_max = CW'(to_bcd(CNT_MAX, DIGITS));

  logic          w_up_ev;
  logic          w_dn_ev;
  logic [CW-1:0] r_cnt;
  logic          r_wrap;
  logic [15:0]   w_cnt16;
  logic [CW-1:0] w_inc_val;
  logic [CW-1:0] w_dec_val;
  logic          w_inc_c;
  logic          w_dec_b;
  logic          w_at_max;
  logic          w_at_min;
  logic          w_load_bcd;
  logic [CW-1:0] w_load_val;

  push_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_Raw  (bus.i_Push[1]),
    .o_Fall (w_up_ev)
  );

  push_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_Raw  (bus.i_Push[0]),
    .o_Fall (w_dn_ev)
  );

  assign w_cnt16   = 16'(r_cnt);
  assign w_inc_val = CW'(bcd_inc(w_cnt16, DIGITS));
  assign w_dec_val = CW'(bcd_dec(w_cnt16, DIGITS));
  assign w_inc_c   = 1'(bcd_inc(w_cnt16, DIGITS) >> 16);
  assign w_dec_b   = 1'(bcd_dec(w_cnt16, DIGITS) >> 16);
  assign w_at_max  = (r_cnt == c_max) || w_inc_c;
  assign w_at_min  = (r_cnt == '0) || w_dec_b;

  // BCD values with valid digits order the same as plain binary.
  always_comb begin
    w_load_bcd = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (bus.i_LoadVal[4*d +: 4] > 4'd9) w_load_bcd = 1'b0;
    end
    w_load_val = (w_load_bcd && (bus.i_LoadVal <= c_max)) ? bus.i_LoadVal : c_max;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (bus.i_Load) begin
        r_cnt <= w_load_val;
      end else if (w_up_ev && w_dn_ev) begin
        r_cnt <= r_cnt;
      end else if (w_up_ev) begin
        if (w_at_max) begin
          r_wrap <= 1'b1;
          if (SAT_MODE == 0) r_cnt <= '0;
        end else begin
          r_cnt <= w_inc_val;
        end
      end else if (w_dn_ev) begin
        if (w_at_min) begin
          r_wrap <= 1'b1;
          if (SAT_MODE == 0) r_cnt <= c_max;
        end else begin
          r_cnt <= w_dec_val;
        end
      end
    end
  end

  logic [PW-1:0]     r_pre;
  logic [IW-1:0]     r_idx;
  logic [IW-1:0]     w_idx_nxt;
  logic              w_pre_tc;
  logic [3:0]        w_digit;
  logic              w_blank;
  logic [6:0]        w_seg;
  logic [6:0]        r_fnd;
  logic [DIGITS-1:0] r_sel;

  assign w_pre_tc = (r_pre == PW'(SCAN_DIV - 1));

  always_comb begin
    w_idx_nxt = r_idx;
    if (w_pre_tc) begin
      w_idx_nxt = (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
    end
  end

  // Display outputs are registered from the next index so select and segments move together.
  assign w_digit = r_cnt[{w_idx_nxt, 2'b00} +: 4];

`ifdef UPDN_LZB_EN
  assign w_blank = (w_idx_nxt != '0) && ((r_cnt >> {w_idx_nxt, 2'b00}) == '0);
`else
  assign w_blank = 1'b0;
`endif

  assign w_seg = (w_blank || (w_digit > 4'd9)) ? 7'h00 : SEG_LUT[w_digit];

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_pre <= '0;
      r_idx <= '0;
      r_sel <= DIGITS'(1);
      r_fnd <= 7'h3F;
    end else begin
      r_pre <= w_pre_tc ? '0 : r_pre + PW'(1);
      r_idx <= w_idx_nxt;
      r_sel <= DIGITS'(1) << w_idx_nxt;
      r_fnd <= w_seg;
    end
  end

  assign bus.o_Cnt    = r_cnt;
  assign bus.o_LED    = r_cnt[3:0];
  assign bus.o_Wrap   = r_wrap;
  assign bus.o_FND    = r_fnd;
  assign bus.o_DigSel = r_sel;
endmodule
`default_nettype wire

// File: tb/tb_updn_bcd_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_updn_bcd_counter
//  Purpose  : Directed self-checking bench; wrap and saturate builds side by side.
//  Revision : 1.0  initial release
// ============================================================================
module tb_updn_bcd_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] push;
  logic       load;
  logic [7:0] lval;

  int n_vec = 0;
  int n_err = 0;
  int wr0   = 0;
  int wr1   = 0;

  always #5 clk = ~clk;

  updn_bcd_counter_if #(.DIGITS(2)) bus0 ();
  updn_bcd_counter_if #(.DIGITS(2)) bus1 ();

  assign bus0.i_Push    = push;
  assign bus0.i_Load    = load;
  assign bus0.i_LoadVal = lval;
  assign bus1.i_Push    = push;
  assign bus1.i_Load    = load;
  assign bus1.i_LoadVal = lval;

  updn_bcd_counter #(
    .DIGITS(2), .CNT_MAX(99), .DB_CYCLES(4), .SCAN_DIV(4), .SAT_MODE(0)
  ) dut0 (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus0)
  );

  updn_bcd_counter #(
    .DIGITS(2), .CNT_MAX(99), .DB_CYCLES(4), .SCAN_DIV(4), .SAT_MODE(1)
  ) dut1 (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus1)
  );

  always @(negedge clk) begin
    if (bus0.o_Wrap === 1'b1) wr0++;
    if (bus1.o_Wrap === 1'b1) wr1++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    lval = v;
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  // The count must hold through edge 6 and change on edge 7 after the press.
  task automatic press(input int b, input logic [7:0] b0, input logic [7:0] a0,
                       input logic [7:0] b1, input logic [7:0] a1, input string tag);
    push[b] = 1'b0;
    step(6);
    chk({tag, "_pre0"}, bus0.o_Cnt, b0);
    chk({tag, "_pre1"}, bus1.o_Cnt, b1);
    step(1);
    chk({tag, "_post0"}, bus0.o_Cnt, a0);
    chk({tag, "_post1"}, bus1.o_Cnt, a1);
    step(13);
    push[b] = 1'b1;
    step(12);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    logic [6:0] fnd_hi;
`ifdef UPDN_LZB_EN
    fnd_hi = 7'h00;
`else
    fnd_hi = 7'h3F;
`endif
    rst  = 1'b1;
    push = 2'b11;
    load = 1'b0;
    lval = 8'h00;
    step(3);
    chk("rst_cnt",  bus0.o_Cnt, 8'h00);
    chk("rst_wrap", bus0.o_Wrap, 1'b0);
    chk("rst_sel",  bus0.o_DigSel, 2'b01);
    chk("rst_fnd",  bus0.o_FND, 7'h3F);
    rst = 1'b0;
    step(2);

    press(1, 8'h00, 8'h01, 8'h00, 8'h01, "up1");
    press(1, 8'h01, 8'h02, 8'h01, 8'h02, "up2");
    press(1, 8'h02, 8'h03, 8'h02, 8'h03, "up3");
    chk("up_nowrap0", wr0, 0);
    chk("up_led", bus0.o_LED, 4'h3);

    do_load(8'h99);
    chk("ld99_0", bus0.o_Cnt, 8'h99);
    press(1, 8'h99, 8'h00, 8'h99, 8'h99, "upmax");
    chk("upmax_wrap0", wr0, 1);
    chk("upmax_wrap1", wr1, 1);

    press(0, 8'h00, 8'h99, 8'h99, 8'h98, "dnmin");
    chk("dnmin_wrap0", wr0, 2);
    chk("dnmin_wrap1", wr1, 1);

    do_load(8'h0A);
    chk("clamp0", bus0.o_Cnt, 8'h99);
    chk("clamp1", bus1.o_Cnt, 8'h99);
    do_load(8'h40);
    press(0, 8'h40, 8'h39, 8'h40, 8'h39, "borrow");

    push[1] = 1'b0;
    step(3);
    push[1] = 1'b1;
    step(15);
    chk("glitch", bus0.o_Cnt, 8'h39);

    push = 2'b00;
    step(20);
    push = 2'b11;
    step(15);
    chk("both0", bus0.o_Cnt, 8'h39);
    chk("both1", bus1.o_Cnt, 8'h39);
    chk("both_wrap0", wr0, 2);

    push[1] = 1'b0;
    step(6);
    lval = 8'h55;
    load = 1'b1;
    step(1);
    load = 1'b0;
    chk("ldwin0", bus0.o_Cnt, 8'h55);
    step(13);
    push = 2'b11;
    step(12);
    chk("ldwin_hold", bus1.o_Cnt, 8'h55);

    do_load(8'h07);
    k = 0;
    while (bus0.o_DigSel !== 2'b10 && k < 20) begin step(1); k++; end
    while (bus0.o_DigSel === 2'b10 && k < 40) begin step(1); k++; end
    chk("scan_sync", {31'd0, k < 40}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("scan_sel0", bus0.o_DigSel, 2'b01);
      chk("scan_fnd0", bus0.o_FND, 7'h07);
      step(1);
    end
    for (int i = 0; i < 4; i++) begin
      chk("scan_sel1", bus0.o_DigSel, 2'b10);
      chk("scan_fnd1", bus0.o_FND, fnd_hi);
      step(1);
    end

    push[1] = 1'b0;
    step(5);
    rst = 1'b1;
    step(1);
    chk("mrst_cnt0", bus0.o_Cnt, 8'h00);
    chk("mrst_cnt1", bus1.o_Cnt, 8'h00);
    chk("mrst_sel",  bus0.o_DigSel, 2'b01);
    chk("mrst_fnd",  bus0.o_FND, 7'h3F);
    chk("mrst_wrap", bus0.o_Wrap, 1'b0);
    push = 2'b11;
    step(2);
    rst = 1'b0;
    step(20);
    chk("mrst_noev", bus0.o_Cnt, 8'h00);
    chk("mrst_wr0", wr0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/updn_bcd_counter.md
Name: updn_bcd_counter

Overview:
- Parametrised successor of the team's single-digit push-button up/down counter.
- Holds a DIGITS-wide BCD count with a configurable ceiling, either wrap or saturate at the limits, a parallel load, and a wrap pulse.
- Debounces and edge-detects both active-low push buttons.
- Time-multiplexes the count onto one shared 7-segment FND bus with a one-hot digit select.

Parameters:
- DIGITS, 2: number of BCD digits, 1..4.
- CNT_MAX, 99: ceiling as a decimal integer, 1..10**DIGITS-1.
- DB_CYCLES, 4: consecutive stable cycles required to accept a button level, >=1.
- SCAN_DIV, 16: clock cycles per display digit slot, >=1.
- SAT_MODE, 0: 0 = wrap at limits, 1 = saturate at limits.

Ports:
- i_Clk  in  1  clock; all logic on rising edge.
- i_Rst  in  1  synchronous, active-high reset.
- i_Push  in  2  raw buttons, active-low (0 = pressed); [1] = up, [0] = down.
- i_Load  in  1  parallel load strobe, already synchronous.
- i_LoadVal  in  4*DIGITS  BCD load value.
- o_Cnt  out  4*DIGITS  current BCD count; digit 0 in bits [3:0].
- o_LED  out  4  o_Cnt[3:0].
- o_Wrap  out  1  one-cycle pulse on wrap, or on a saturation hit when SAT_MODE=1.
- o_FND  out  7  segments of the selected digit, active-high, bit0=a .. bit6=g.
- o_DigSel  out  DIGITS  one-hot active-high digit enable.

Behaviour:
- Reset: when i_Rst=1 at an edge, every state register takes its reset value at that edge. This overrides load, events and scan, including mid-debounce.
  - Reset values: o_Cnt=0, o_Wrap=0, scan index 0, o_DigSel=1, o_FND=7'h3F ("0").
  - Synchroniser FFs and accepted button levels reset to 1 (released).
- Input path, per button: 2-FF synchroniser, then debounce counter.
  - The debounce counter increments while the synchronised level differs from the accepted level and clears otherwise.
  - When it reaches DB_CYCLES, the accepted level takes the synchronised level.
  - A press event is a 1->0 transition of the accepted level, one cycle wide. Release produces no event.
- Latency: a clean raw press held steady changes o_Cnt exactly DB_CYCLES+3 edges after the raw transition.
- Glitches shorter than DB_CYCLES cycles produce no event.
- Count update priority, per edge:
  1. i_Load=1: o_Cnt<=i_LoadVal. Values above CNT_MAX or with a non-BCD digit (>9) clamp to CNT_MAX. Pending events that cycle are dropped.
  2. Up and down events in the same cycle: no change.
  3. Up event: BCD increment with decimal carry. At CNT_MAX, goes to 0 (SAT_MODE=0) or holds (SAT_MODE=1); o_Wrap=1 next cycle in both modes.
  4. Down event: BCD decrement with borrow. At 0, goes to CNT_MAX (SAT_MODE=0) or holds (SAT_MODE=1); o_Wrap=1 next cycle.
- o_Wrap is registered and high for exactly one cycle per qualifying event.
- Display scan:
  - A prescaler counts 0..SCAN_DIV-1. At terminal count the scan index advances and wraps from DIGITS-1 to 0.
  - o_DigSel and o_FND are registered and show the same digit of the current o_Cnt.
  - A count change is visible on the FND within one slot.
- Segment codes 0-9 are the standard common-cathode pattern: 3F 06 5B 4F 66 6D 7D 07 7F 6F.

Optional Feature:
- Macro: UPDN_LZB_EN.
- When defined, leading-zero blanking is on: any digit above the most significant non-zero digit drives o_FND=0. Digit 0 is never blanked.
- When undefined, all digits always display, including leading zeros.
- o_Cnt, o_DigSel and timing are identical in both builds.

Decomposition:
- Package updn_pkg holds:
  - segment code constant array SEG_LUT[0:9];
  - function to_bcd(int, DIGITS), used for the CNT_MAX constant;
  - function bcd_inc/bcd_dec returning {carry, value}.
- Sub-module push_debounce: synchroniser, debounce counter, accepted level and fall-edge event for one button, parametrised by DB_CYCLES. Instantiated twice.
- Count logic and scan logic stay in the top module.

Test Plan:
- Reset, then 3 clean up presses (each held 20 cycles, DB_CYCLES=4) -> o_Cnt=0x03; each step lands 7 edges after its press; o_Wrap stays 0.
- Load 0x99, then one up press: SAT_MODE=0 -> o_Cnt=0x00 with a one-cycle o_Wrap; SAT_MODE=1 -> o_Cnt stays 0x99 with o_Wrap pulsed.
- From 0x00, one down press -> 0x99 (wrap build). Load 0x0A gives 0x99 (clamp); load 0x40 then down gives 0x39 (borrow).
- 3-cycle glitch low on i_Push[1] -> no count change. Both buttons pressed on the same cycle -> no change. Load coincident with an up event -> load value wins.
- Scan with SCAN_DIV=4 and count 0x07:
  - o_DigSel sequence 01,10 every 4 cycles.
  - o_FND is 07 in the digit-0 slot.
  - In the digit-1 slot o_FND is 3F, or 00 when built with UPDN_LZB_EN.
- Assert i_Rst mid-debounce and mid-scan -> all reset values at the next edge; the interrupted press produces no event after release of reset.
